wb_bram_ctrl: RTL and testbench

WB_BRAM_CTRL -- requirements
Module: wb_bram_ctrl

---
 rtl/wb_bram_ctrl_if.sv | 21 ++
 rtl/wb_bram_ctrl.sv | 144 ++++++++++++++
 tb/tb_wb_bram_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_ctrl_if.sv
// Wishbone slave bundle between the arbiter RAM port and the block-RAM controller.
interface wb_bram_ctrl_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave in front of a word-organised block RAM with a fixed, programmable
// accept-to-ack latency; accesses outside the RAM window are acked but have no effect.
module wb_bram_ctrl #(
   parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned DELAY     = 10
) (
   input logic           wb_clk_i,
   input logic           wb_rst_n,
   wb_bram_ctrl_if.slave wbs
);
   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam logic [CW-1:0] CNT_LAST = CW'((DELAY > 0) ? (DELAY - 1) : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DW-1:0] adr;
      logic          we;
      logic [SW-1:0] sel;
      logic [DW-1:0] dat;
   } req_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   req_t          req_q;
   req_t          bus_req_c;
   req_t          acc_c;
   logic          valid_c;
   logic          accept_c;
   logic          enter_ack_c;
   logic [DW-1:0] off_c;
   logic          in_win_c;
   logic [AW-1:0] idx_c;
   logic          mem_we_c;
   logic          mem_rd_c;
   logic          ack_q;
   logic [DW-1:0] dat_q;

   logic [DW-1:0] mem [MEM_WORDS];

   // No request is seen while reset is held, so nothing can reach the RAM then.
   assign valid_c = wbs.wbs_stb_i & wbs.wbs_cyc_i & wb_rst_n;

   assign bus_req_c.adr = wbs.wbs_adr_i;
   assign bus_req_c.we  = wbs.wbs_we_i;
   assign bus_req_c.sel = wbs.wbs_sel_i;
   assign bus_req_c.dat = wbs.wbs_dat_i;

   // In IDLE the access is taken straight off the bus so a zero-delay ack can act on it.
   assign acc_c    = (state_q == IDLE) ? bus_req_c : req_q;
   assign off_c    = acc_c.adr - ADDR_BASE;
   assign in_win_c = (off_c >> 2) < DW'(MEM_WORDS);
   assign idx_c    = acc_c.adr[AW+1:2];
   assign mem_we_c = enter_ack_c &  acc_c.we & in_win_c;
   assign mem_rd_c = enter_ack_c & ~acc_c.we & in_win_c;

   // State and latency counter.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept_c    = 1'b0;
      enter_ack_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (valid_c) begin
               accept_c = 1'b1;
               cnt_d    = '0;
               if (DELAY == 0) begin
                  state_d     = ACK;
                  enter_ack_c = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!valid_c) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ACK;
               enter_ack_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Latched request plus registered ack and read data.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         req_q <= '0;
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         if (accept_c) begin
            req_q <= bus_req_c;
         end
         ack_q <= enter_ack_c;
         dat_q <= mem_rd_c ? mem[idx_c] : '0;
      end
   end

   // RAM array keeps its contents across reset; writes land on the edge entering ACK.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we_c) begin
         for (int b = 0; b < int'(SW); b++) begin
            if (acc_c.sel[b]) begin
               mem[idx_c][8*b +: 8] <= acc_c.dat[8*b +: 8];
            end
         end
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Randomised scoreboard bench for wb_bram_ctrl: a DELAY=10 instance carries most traffic,
// a DELAY=0 instance covers the zero-latency and post-reset first-accept behaviour.
module tb_wb_bram_ctrl;
   localparam logic [31:0] BASE  = 32'h3800_0000;
   localparam int unsigned WORDS = 1024;
   localparam int unsigned D_A   = 10;
   localparam int unsigned D_B   = 0;

   typedef struct {
      logic [31:0] data;
      bit          chk;
      int unsigned cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc_cnt = 0;

   logic        stb   = 1'b0;
   logic        cyc_s = 1'b0;
   logic        we    = 1'b0;
   logic [3:0]  sel   = 4'h0;
   logic [31:0] wdat  = 32'h0;
   logic [31:0] adr   = 32'h0;
   int          tgt   = 0;

   int checks = 0;
   int errors = 0;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [31:0] model   [2][WORDS];
   bit          written [2][WORDS];
   int          wr_list[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   wb_bram_ctrl_if bus_a ();
   wb_bram_ctrl_if bus_b ();

   assign bus_a.wbs_stb_i = stb & (tgt == 0);
   assign bus_a.wbs_cyc_i = cyc_s & (tgt == 0);
   assign bus_a.wbs_we_i  = we;
   assign bus_a.wbs_sel_i = sel;
   assign bus_a.wbs_dat_i = wdat;
   assign bus_a.wbs_adr_i = adr;
   assign bus_b.wbs_stb_i = stb & (tgt == 1);
   assign bus_b.wbs_cyc_i = cyc_s & (tgt == 1);
   assign bus_b.wbs_we_i  = we;
   assign bus_b.wbs_sel_i = sel;
   assign bus_b.wbs_dat_i = wdat;
   assign bus_b.wbs_adr_i = adr;

   wb_bram_ctrl #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .DELAY(D_A)) dut_a (
      .wb_clk_i (clk),
      .wb_rst_n (rst_n),
      .wbs      (bus_a)
   );

   wb_bram_ctrl #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .DELAY(D_B)) dut_b (
      .wb_clk_i (clk),
      .wb_rst_n (rst_n),
      .wbs      (bus_b)
   );

   // Monitor: every ack pops one expectation; outside an ack the data bus must be zero.
   task automatic check_port(input int t, input logic ack, input logic [31:0] dat);
      exp_t e;
      bit   have;
      if (ack !== 1'b0) begin
         have = 1'b0;
         if (t == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
         if (t == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
         checks++;
         if (!have) begin
            errors++;
            $display("FAIL unexpected_ack port%0d: ack=%b at cycle %0d, required no ack", t, ack, cyc_cnt);
         end else begin
            if (cyc_cnt != e.cyc) begin
               errors++;
               $display("FAIL ack_cycle port%0d: ack at cycle %0d, required cycle %0d", t, cyc_cnt, e.cyc);
            end
            if (e.chk) begin
               checks++;
               if (dat !== e.data) begin
                  errors++;
                  $display("FAIL read_data port%0d cycle %0d: got %h, required %h", t, cyc_cnt, dat, e.data);
               end
            end
         end
      end else begin
         checks++;
         if (dat !== 32'h0) begin
            errors++;
            $display("FAIL idle_dat port%0d cycle %0d: dat_o %h while ack low, required 0", t, cyc_cnt, dat);
         end
      end
   endtask

   always @(negedge clk) begin
      check_port(0, bus_a.wbs_ack_o, bus_a.wbs_dat_o);
      check_port(1, bus_b.wbs_ack_o, bus_b.wbs_dat_o);
   end

   // One bus transfer; abort_at>0 drops the request in that cycle, keep leaves stb high after ack.
   task automatic do_req(input int t, input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int abort_at, input bit keep, input bit rel);
      exp_t        e;
      int unsigned c0;
      int unsigned off;
      int          idx;
      bit          inwin;
      bit          got;
      @(posedge clk); #1;
      if (rel) rst_n = 1'b1;
      tgt = t; stb = 1'b1; cyc_s = 1'b1; we = w; adr = a; sel = s; wdat = d;
      c0    = cyc_cnt;
      off   = a - BASE;
      inwin = (off >> 2) < WORDS;
      idx   = int'(off >> 2);
      if (abort_at > 0) begin
         repeat (abort_at) begin @(posedge clk); #1; end
         if ($urandom_range(0, 1) == 0) stb = 1'b0; else cyc_s = 1'b0;
         @(posedge clk); #1;
         stb = 1'b0; cyc_s = 1'b0;
      end else begin
         e.cyc  = c0 + ((t == 0) ? D_A : D_B) + 1;
         e.chk  = !w;
         e.data = 32'h0;
         if (inwin && w) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) model[t][idx][8*b +: 8] = d[8*b +: 8];
            if (s == 4'hF && !written[t][idx]) begin
               written[t][idx] = 1'b1;
               if (t == 0) wr_list.push_back(idx);
            end
         end
         if (inwin && !w) e.data = model[t][idx];
         if (t == 0) q_a.push_back(e); else q_b.push_back(e);
         got = 1'b0;
         for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((t == 0) ? bus_a.wbs_ack_o : bus_b.wbs_ack_o) got = 1'b1;
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL ack_timeout port%0d adr %h: no ack within 40 cycles, required ack", t, a);
         end
         if (!keep) begin
            @(posedge clk); #1;
            stb = 1'b0; cyc_s = 1'b0;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int unsigned r;
      int          idx;
      logic [31:0] a;
      bit          kp;

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_a.wbs_ack_o !== 1'b0 || bus_a.wbs_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: ack %b dat %h, required 0 and 0", bus_a.wbs_ack_o, bus_a.wbs_dat_o);
      end

      // Basic write/read, first accept right after reset release.
      do_req(0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, 1'b1);
      do_req(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, 1'b0, 1'b0);

      // Byte lanes, ignored low address bits, and an all-lanes-off write.
      do_req(0, 1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, 0, 1'b0, 1'b0);
      do_req(0, 1'b1, BASE + 32'h22, 4'b0101, 32'hAABB_CCDD, 0, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE + 32'h21, 4'hF, 32'h0, 0, 1'b0, 1'b0);
      do_req(0, 1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE + 32'h20, 4'hF, 32'h0, 0, 1'b0, 1'b0);

      // Aborted read and write, then reads acked with normal latency.
      do_req(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 5, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, 1'b0, 1'b0);
      do_req(0, 1'b1, BASE + 32'h10, 4'hF, 32'h0BAD_0BAD, 7, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, 1'b0, 1'b0);

      // Window edges.
      do_req(0, 1'b1, BASE, 4'hF, 32'hA5A5_0001, 0, 1'b0, 1'b0);
      do_req(0, 1'b1, BASE + 32'h1000, 4'hF, 32'h1234_5678, 0, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE, 4'hF, 32'h0, 0, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE + 32'h1000, 4'hF, 32'h0, 0, 1'b0, 1'b0);
      do_req(0, 1'b1, BASE + 32'hFFC, 4'hF, 32'h7777_8888, 0, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE + 32'hFFC, 4'hF, 32'h0, 0, 1'b0, 1'b0);
      do_req(0, 1'b0, BASE - 32'h4, 4'hF, 32'h0, 0, 1'b0, 1'b0);

      // Back-to-back with strobe held through the first ack.
      do_req(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, 1'b1, 1'b0);
      do_req(0, 1'b0, BASE + 32'h20, 4'hF, 32'h0, 0, 1'b0, 1'b0);

      // Reset in the middle of a write, then a zero-delay read at the first edge after release.
      do_req(1, 1'b1, BASE + 32'h40, 4'hF, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
      @(posedge clk); #1;
      tgt = 0; stb = 1'b1; cyc_s = 1'b1; we = 1'b1; sel = 4'hF;
      adr = BASE + 32'h10; wdat = 32'h5555_5555;
      repeat (6) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_a.wbs_ack_o !== 1'b0 || bus_a.wbs_dat_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_abort: ack %b dat %h, required 0 and 0", bus_a.wbs_ack_o, bus_a.wbs_dat_o);
      end
      stb = 1'b0; cyc_s = 1'b0;
      repeat (2) @(posedge clk);
      do_req(1, 1'b0, BASE + 32'h40, 4'hF, 32'h0, 0, 1'b0, 1'b1);
      do_req(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, 0, 1'b0, 1'b0);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 200; n++) begin
         r   = $urandom_range(0, 99);
         idx = int'($urandom_range(0, 63));
         kp  = ($urandom_range(0, 4) == 0) && (n < 199);
         if (r < 10) begin
            do_req(0, 1'($urandom_range(0, 1)), BASE + 32'(idx * 4), 4'hF, $urandom,
                   int'($urandom_range(1, D_A)), 1'b0, 1'b0);
         end else if (r < 45 || wr_list.size() == 0) begin
            a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            do_req(0, 1'b1, a, 4'($urandom_range(0, 15)), $urandom, 0, kp, 1'b0);
         end else if (r < 90) begin
            idx = wr_list[$urandom_range(0, wr_list.size() - 1)];
            a   = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            do_req(0, 1'b0, a, 4'hF, 32'h0, 0, kp, 1'b0);
         end else begin
            if (r[0]) a = BASE + 32'h1000 + ($urandom & 32'h00FF_FFFC);
            else      a = BASE - 32'(4 * $urandom_range(1, 64));
            do_req(0, 1'($urandom_range(0, 1)), a, 4'hF, $urandom, 0, kp, 1'b0);
         end
      end

      repeat (20) @(posedge clk);
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         $display("FAIL pending_acks: %0d/%0d expectations left, required 0/0", q_a.size(), q_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
